alu_seq_responder: RTL



---
 rtl/alu_seq_responder.sv | 109 ++++++++++
 1 files changed

// File: rtl/alu_seq_responder.sv
// Request/valid ALU responder: add/sub in one cycle, iterative shift-add multiply
// and bit-serial shift-left. All outputs registered; four-phase valid handshake.
module alu_seq_responder #(
    parameter int width = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             request,
    input  logic [width-1:0] operandA,
    input  logic [width-1:0] operandB,
    input  logic [1:0]       opcode,
    output logic [width-1:0] result,
    output logic             valid,
    output logic             busy
);
    localparam int SW   = $clog2(width);
    localparam int CNTW = SW + 1;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t            state;
    logic [1:0]        op_r;
    logic [width-1:0]  a_r;
    logic [width-1:0]  b_r;
    logic [width-1:0]  acc;
    logic [CNTW-1:0]   cnt;
    logic [width-1:0]  mul_term;

    assign mul_term = b_r[0] ? a_r : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            op_r   <= '0;
            a_r    <= '0;
            b_r    <= '0;
            acc    <= '0;
            cnt    <= '0;
            result <= '0;
            valid  <= 1'b0;
            busy   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (request) begin
                        op_r <= opcode;
                        a_r  <= operandA;
                        b_r  <= operandB;
                        acc  <= '0;
                        busy <= 1'b1;
                        case (opcode)
                            OP_ADD: begin
                                result <= operandA + operandB;
                                valid  <= 1'b1;
                                state  <= DONE;
                            end
                            OP_SUB: begin
                                result <= operandA - operandB;
                                valid  <= 1'b1;
                                state  <= DONE;
                            end
                            OP_MUL: begin
                                cnt   <= CNTW'(width);
                                state <= EXEC;
                            end
                            default: begin
                                // Zero shift skips EXEC entirely, matching add timing
                                if (operandB[SW-1:0] == '0) begin
                                    result <= operandA;
                                    valid  <= 1'b1;
                                    state  <= DONE;
                                end else begin
                                    cnt   <= {1'b0, operandB[SW-1:0]};
                                    state <= EXEC;
                                end
                            end
                        endcase
                    end
                end
                EXEC: begin
                    cnt <= cnt - 1'b1;
                    a_r <= a_r << 1;
                    if (op_r == OP_MUL) begin
                        acc <= acc + mul_term;
                        b_r <= b_r >> 1;
                    end
                    // Final iteration folds its step straight into result
                    if (cnt == CNTW'(1)) begin
                        result <= (op_r == OP_MUL) ? (acc + mul_term) : (a_r << 1);
                        valid  <= 1'b1;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    if (!request) begin
                        valid <= 1'b0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
